fp_mismatch_log: RTL and testbench
==================================

Name: fp_mismatch_log

Overview:
- Consumer end of the binary16 adder-comparison sweep.
- The sweep engine offers one result record per handshake: operands a and b, sum s from the minimal-length adder, and checkS from the exact adder.
- This block counts tests and mismatches and buffers the offending records in a small FIFO.
- A button-stepped reader FSM pops the buffered records and presents each field on the 16-bit hex-digit bus that drives the 7-segment display.

Parameters:
- NEXP, 5, exponent width; record word width W = NEXP+NSIG+1.
- NSIG, 10, significand width.
- DEPTH, 8, mismatch FIFO depth; must be a power of 2.
- LOG2D, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clr  input  1  synchronous active-high reset.
- in_valid  input  1  a result record is offered.
- in_ready  output  1  the record is accepted this cycle when in_valid && in_ready.
- in_a  input  W  operand a.
- in_b  input  W  operand b.
- in_s  input  W  minimal-length adder sum.
- in_chk  input  W  exact adder sum.
- rd_step  input  1  one-cycle pulse, already debounced and edge-detected, that advances the display.
- hexdigits  output  16  value to display; upper bits are zero when W < 16.
- field  output  2  field being displayed: 0=a, 1=b, 2=s, 3=chk.
- empty  output  1  FIFO holds no records.
- full  output  1  FIFO holds DEPTH records.
- n_tests  output  32  count of accepted records; wraps modulo 2^32.
- n_err  output  16  count of mismatches; saturates at 16'hFFFF.
- overflow  output  1  sticky: at least one mismatch record was lost.

Behaviour:
- Reset (clr=1 at a posedge): FIFO is emptied and head/tail/count are cleared.
  - n_tests=0, n_err=0, overflow=0.
  - FSM goes to EMPTY, field=0, hexdigits=16'h0000, empty=1, full=0.
  - clr takes priority over every other input in the same cycle.
- Accept: occurs when in_valid && in_ready.
  - n_tests increments.
  - The record is a mismatch when in_s != in_chk, compared bitwise with no NaN or ±0 equivalence.
  - A mismatch increments n_err (saturating) and pushes {a,b,s,chk} at the tail.
  - A matching record is counted only and not stored.
- in_ready = ~full. It is driven from registered state only, with no same-cycle bypass from a pop.
- FIFO: count, head and tail are registered.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: both take effect and count is unchanged.
  - A push into an empty FIFO is visible at the head on the next cycle.
- Reader FSM states: EMPTY, SHOW_A, SHOW_B, SHOW_S, SHOW_C.
  - EMPTY: hexdigits = n_err. rd_step is ignored. When the FIFO is non-empty, go to SHOW_A on the next cycle.
  - SHOW_A -> SHOW_B -> SHOW_S -> SHOW_C, each advancing on rd_step. hexdigits is the head record's a, b, s or chk respectively, and field follows the state.
  - SHOW_C with rd_step: pop the head. Go to SHOW_A if count > 1 (or if a push coincides with the pop); otherwise go to EMPTY.
- hexdigits and field are combinational from FSM state and the FIFO head. Latency from accept to display is 1 cycle.

Optional Feature:
- Macro: CMPLOG_OVERWRITE_EN.
- Defined:
  - in_ready is tied to 1.
  - A mismatch push while full, with no coincident pop, discards the oldest record: head advances, the new record is written at the tail, and overflow is set.
  - If the reader is in SHOW_B, SHOW_S or SHOW_C at that moment, it returns to SHOW_A to show the new head.
  - A push while full with a coincident pop behaves as a normal push plus pop; overflow is not set.
- Undefined:
  - Back-pressure through in_ready = ~full.
  - overflow stays 0.

Decomposition:
- Package cmplog_pkg holds:
  - the reader state encoding (EMPTY, SHOW_A, SHOW_B, SHOW_S, SHOW_C);
  - field codes F_A=0, F_B=1, F_S=2, F_C=3;
  - record layout offsets for a/b/s/chk within a 4W-bit word.
- Sub-module cmplog_fifo: synchronous FIFO of 4W-bit words with push, pop, head, count, full and empty.
  - Overwrite-when-full behaviour is enabled by CMPLOG_OVERWRITE_EN.

Test Plan:
- clr, then 5 matching records (in_s = in_chk = 16'h3C00) -> n_tests=5, n_err=0, empty=1, hexdigits=16'h0000.
- One mismatch: a=16'h3C00, b=16'h0001, s=16'h3C00, chk=16'h3C01.
  - Next cycle: SHOW_A with hexdigits=16'h3C00.
  - 3 rd_step pulses show 16'h0001, 16'h3C00, 16'h3C01.
  - 4th pulse -> EMPTY, hexdigits=16'h0001.
- 9 mismatches with in_valid held high, macro undefined -> full=1 and in_ready=0 after the 8th; n_tests stays 8 until a pop, then the 9th is accepted.
- Same 9 mismatches with CMPLOG_OVERWRITE_EN -> n_tests=9, n_err=9, overflow=1, head record is the 2nd mismatch.
- FIFO full and the reader in SHOW_C; rd_step and a mismatch in the same cycle -> count stays 8, overflow stays 0, FSM goes to SHOW_A.
- n_err preloaded by 65536 mismatches -> saturates at 16'hFFFF; clr mid-display -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/cmplog_pkg.sv
// Shared definitions for the binary16 adder mismatch logger:
// reader state encoding, display field codes and record slot layout.
// A record word is {a, b, s, chk}, each W bits, with a in the top slot.
package cmplog_pkg;

  // Reader FSM states
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    SHOW_A = 3'd1,
    SHOW_B = 3'd2,
    SHOW_S = 3'd3,
    SHOW_C = 3'd4
  } rd_state_e;

  // Field codes presented on the field output
  localparam logic [1:0] F_A = 2'd0;
  localparam logic [1:0] F_B = 2'd1;
  localparam logic [1:0] F_S = 2'd2;
  localparam logic [1:0] F_C = 2'd3;

  // Slot index of each operand inside the record word; bit offset = slot * W
  localparam int SLOT_A = 3;
  localparam int SLOT_B = 2;
  localparam int SLOT_S = 1;
  localparam int SLOT_C = 0;

  // Bit offset of a slot within a record of W-bit fields
  function automatic int rec_off(input int slot, input int w);
    return slot * w;
  endfunction

endpackage

// File: rtl/cmplog_fifo.sv
// Synchronous FIFO of record words with registered head/tail/count and a
// combinational head read so a push into an empty FIFO shows next cycle.
// Optional macro CMPLOG_OVERWRITE_EN: a push while full with no coincident
// pop drops the oldest entry instead of being refused.
module cmplog_fifo
  import cmplog_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int LOG2D = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [LOG2D:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overwrote
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2D-1:0] head_q, head_d;
  logic [LOG2D-1:0] tail_q, tail_d;
  logic [LOG2D:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic             ovw;

  assign full  = (count_q == (LOG2D + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[head_q];

  assign do_pop = pop && !empty;
`ifdef CMPLOG_OVERWRITE_EN
  // Full and not popping: accept anyway by retiring the oldest entry
  assign do_push = push;
  assign ovw     = push && full && !do_pop;
`else
  assign do_push = push && (!full || do_pop);
  assign ovw     = 1'b0;
`endif
  assign overwrote = ovw;

  // Pointer and occupancy next-state; overwrite keeps count fixed
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop || ovw) head_d = head_q + 1'b1;
    if (do_push)       tail_d = tail_q + 1'b1;
    if (do_push && !do_pop && !ovw)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push)         count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array write port; contents need no reset
  always_ff @(posedge clk) begin
    if (!clr && do_push) mem_q[tail_q] <= din;
  end

endmodule

// File: rtl/fp_mismatch_log.sv
// Consumer end of the binary16 adder sweep: counts results, buffers records
// whose minimal adder sum differs from the exact sum, and steps the buffered
// records out to the hex display one field per rd_step pulse.
// Optional macro CMPLOG_OVERWRITE_EN: never back-pressure; when full the
// oldest record is dropped and overflow becomes sticky-set.
module fp_mismatch_log
  import cmplog_pkg::*;
#(
  parameter int NEXP  = 5,
  parameter int NSIG  = 10,
  parameter int DEPTH = 8,
  parameter int LOG2D = 3
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in_a,
  input  logic [NEXP+NSIG:0]     in_b,
  input  logic [NEXP+NSIG:0]     in_s,
  input  logic [NEXP+NSIG:0]     in_chk,
  input  logic                   rd_step,
  output logic [15:0]            hexdigits,
  output logic [1:0]             field,
  output logic                   empty,
  output logic                   full,
  output logic [31:0]            n_tests,
  output logic [15:0]            n_err,
  output logic                   overflow
);

  localparam int W = NEXP + NSIG + 1;

  rd_state_e      state_q, state_d;
  logic [31:0]    n_tests_q, n_tests_d;
  logic [15:0]    n_err_q, n_err_d;
  logic           overflow_q, overflow_d;

  logic           accept;
  logic           push;
  logic           pop;
  logic [4*W-1:0] head;
  logic [LOG2D:0] count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           overwrote;
  logic [W-1:0]   field_word;
  logic [15:0]    field_hex;

`ifdef CMPLOG_OVERWRITE_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = ~fifo_full;
`endif

  assign accept = in_valid && in_ready;
  assign push   = accept && (in_s != in_chk);
  assign pop    = rd_step && (state_q == SHOW_C);

  cmplog_fifo #(
    .WIDTH (4 * W),
    .DEPTH (DEPTH),
    .LOG2D (LOG2D)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .din       ({in_a, in_b, in_s, in_chk}),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overwrote (overwrote)
  );

  // Statistics next-state: wrapping test count, saturating error count
  always_comb begin
    n_tests_d  = n_tests_q;
    n_err_d    = n_err_q;
    overflow_d = overflow_q | overwrote;
    if (accept) n_tests_d = n_tests_q + 32'd1;
    if (push && (n_err_q != 16'hFFFF)) n_err_d = n_err_q + 16'd1;
  end

  // Reader next-state; a new record is shown the cycle after it is pushed
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:  if (!fifo_empty || push) state_d = SHOW_A;
      SHOW_A: if (rd_step) state_d = SHOW_B;
      SHOW_B: if (rd_step) state_d = SHOW_S;
      SHOW_S: if (rd_step) state_d = SHOW_C;
      SHOW_C: if (rd_step) state_d = ((count > (LOG2D + 1)'(1)) || push) ? SHOW_A : EMPTY;
      default: state_d = EMPTY;
    endcase
    // Head was replaced underneath the reader: restart on the new head
    if (overwrote) state_d = SHOW_A;
  end

  // State and statistics registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= EMPTY;
      n_tests_q  <= '0;
      n_err_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_tests_q  <= n_tests_d;
      n_err_q    <= n_err_d;
      overflow_q <= overflow_d;
    end
  end

  // Field selection from the head record for the current reader state
  always_comb begin
    field      = F_A;
    field_word = head[rec_off(SLOT_A, W) +: W];
    case (state_q)
      SHOW_B: begin field = F_B; field_word = head[rec_off(SLOT_B, W) +: W]; end
      SHOW_S: begin field = F_S; field_word = head[rec_off(SLOT_S, W) +: W]; end
      SHOW_C: begin field = F_C; field_word = head[rec_off(SLOT_C, W) +: W]; end
      default: ;
    endcase
  end

  // Fit the record field onto the 16-bit display bus
  generate
    if (W >= 16) begin : g_trunc
      assign field_hex = field_word[15:0];
    end else begin : g_zext
      assign field_hex = {{(16 - W){1'b0}}, field_word};
    end
  endgenerate

  assign hexdigits = (state_q == EMPTY) ? n_err_q : field_hex;
  assign empty     = fifo_empty;
  assign full      = fifo_full;
  assign n_tests   = n_tests_q;
  assign n_err     = n_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp_mismatch_log.sv
// Self-checking bench for fp_mismatch_log with a queue-based reference model.
module tb_fp_mismatch_log;

  localparam int DEPTH = 8;
`ifdef CMPLOG_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0, in_s = '0, in_chk = '0;
  logic        rd_step = 1'b0;
  logic [15:0] hexdigits;
  logic [1:0]  field;
  logic        empty, full;
  logic [31:0] n_tests;
  logic [15:0] n_err;
  logic        overflow;

  always #5 clk = ~clk;

  fp_mismatch_log #(.NEXP(5), .NSIG(10), .DEPTH(8), .LOG2D(3)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_chk(in_chk),
    .rd_step(rd_step), .hexdigits(hexdigits), .field(field),
    .empty(empty), .full(full), .n_tests(n_tests), .n_err(n_err),
    .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model: queue of records {a,b,s,chk}; view 0 = counter shown,
  // view 1..4 = field a/b/s/chk of the oldest record shown
  logic [63:0] mq[$];
  int          m_view;
  logic [31:0] m_tests;
  logic [15:0] m_err;
  bit          m_ovf;
  bit          m_acc;
  int          idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_hex();
    if (m_view == 0) return m_err;
    return mq[0][(4 - m_view) * 16 +: 16];
  endfunction

  function automatic bit m_ready();
    return OVW ? 1'b1 : (mq.size() < DEPTH);
  endfunction

  task automatic model_step();
    bit was_full, pop, push, ovw;
    int nxt;
    m_acc = 1'b0;
    if (clr) begin
      mq.delete();
      m_view = 0; m_tests = 0; m_err = 0; m_ovf = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    m_acc = in_valid && m_ready();
    push  = m_acc && (in_s != in_chk);
    pop   = (m_view == 4) && rd_step;
    ovw   = push && was_full && !pop;
    if (m_acc) m_tests++;
    if (push && m_err != 16'hFFFF) m_err++;
    if (m_view == 0)   nxt = (mq.size() > 0 || push) ? 1 : 0;
    else if (ovw)      nxt = 1;
    else if (rd_step)  nxt = (m_view == 4) ? ((mq.size() > 1 || push) ? 1 : 0) : m_view + 1;
    else               nxt = m_view;
    if (pop) void'(mq.pop_front());
    if (ovw) begin void'(mq.pop_front()); m_ovf = 1; end
    if (push) mq.push_back({in_a, in_b, in_s, in_chk});
    m_view = nxt;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("hexdigits", {16'h0, hexdigits}, {16'h0, m_hex()});
      check("field", {30'h0, field}, (m_view == 0) ? 32'd0 : 32'(m_view - 1));
      check("empty", {31'h0, empty}, {31'h0, (mq.size() == 0)});
      check("full", {31'h0, full}, {31'h0, (mq.size() == DEPTH)});
      check("in_ready", {31'h0, in_ready}, {31'h0, m_ready()});
      check("n_tests", n_tests, m_tests);
      check("n_err", {16'h0, n_err}, {16'h0, m_err});
      check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_rec(input int k);
    in_a = 16'(k); in_b = 16'h1000 + 16'(k); in_s = 16'h2000 + 16'(k); in_chk = 16'h3000 + 16'(k);
  endtask

  // Advance the held mismatch sequence once the model saw it accepted
  task automatic hold_advance();
    if (m_acc && in_valid) begin
      if (idx < 9) begin idx++; set_rec(idx); end
      else in_valid = 1'b0;
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    // Reset
    clr = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    clr = 1'b0;
    lit("rst_hex", {16'h0, hexdigits}, 32'h0);
    lit("rst_empty", {31'h0, empty}, 32'd1);
    lit("rst_ntests", n_tests, 32'd0);

    // Five matching records
    in_valid = 1'b1; in_s = 16'h3C00; in_chk = 16'h3C00;
    for (int i = 0; i < 5; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    lit("match_ntests", n_tests, 32'd5);
    lit("match_nerr", {16'h0, n_err}, 32'd0);
    lit("match_empty", {31'h0, empty}, 32'd1);
    lit("match_hex", {16'h0, hexdigits}, 32'h0);

    // Single mismatch, stepped through all four fields
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h0001; in_s = 16'h3C00; in_chk = 16'h3C01;
    tick();
    in_valid = 1'b0;
    lit("one_a", {16'h0, hexdigits}, 32'h3C00);
    rd_step = 1'b1;
    tick(); lit("one_b", {16'h0, hexdigits}, 32'h0001);
    tick(); lit("one_s", {16'h0, hexdigits}, 32'h3C00);
    tick(); lit("one_c", {16'h0, hexdigits}, 32'h3C01);
    lit("one_field", {30'h0, field}, 32'd3);
    tick();
    rd_step = 1'b0;
    lit("one_done_hex", {16'h0, hexdigits}, 32'h0001);
    lit("one_done_empty", {31'h0, empty}, 32'd1);

    // Nine mismatches with in_valid held high
    idx = 1; set_rec(idx); in_valid = 1'b1;
    repeat (12) begin tick(); hold_advance(); end
    if (OVW) begin
      lit("ovw_ntests", n_tests, 32'd15);
      lit("ovw_nerr", {16'h0, n_err}, 32'd10);
      lit("ovw_flag", {31'h0, overflow}, 32'd1);
      lit("ovw_head", {16'h0, hexdigits}, 32'h0002);
    end else begin
      lit("bp_full", {31'h0, full}, 32'd1);
      lit("bp_ready", {31'h0, in_ready}, 32'd0);
      lit("bp_ntests", n_tests, 32'd14);
      lit("bp_head", {16'h0, hexdigits}, 32'h0001);
    end
    rd_step = 1'b1;
    repeat (4) begin tick(); hold_advance(); end
    rd_step = 1'b0;
    tick(); hold_advance();
    lit("after_pop_ntests", n_tests, 32'd15);
    lit("after_pop_full", {31'h0, full}, OVW ? 32'd0 : 32'd1);

    // Walk to SHOW_C, then pop and push a mismatch in the same cycle
    rd_step = 1'b1;
    repeat (3) begin tick(); end
    lit("at_c_field", {30'h0, field}, 32'd3);
    in_valid = 1'b1; in_a = 16'h5555; in_b = 16'h6666; in_s = 16'h7777; in_chk = 16'h7778;
    tick();
    in_valid = 1'b0; rd_step = 1'b0;
    lit("popush_field", {30'h0, field}, 32'd0);
    lit("popush_full", {31'h0, full}, OVW ? 32'd0 : 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr      = ($urandom_range(0, 299) == 0);
      in_valid = $urandom_range(0, 1);
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      in_s     = 16'($urandom);
      in_chk   = $urandom_range(0, 1) ? in_s : 16'($urandom);
      rd_step  = ($urandom_range(0, 2) == 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; rd_step = 1'b0;

    // Clear in the middle of a display
    clr = 1'b1; tick(); clr = 1'b0;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_s = 16'h0F0F; in_chk = 16'hF0F0;
    tick();
    in_valid = 1'b0; rd_step = 1'b1;
    tick();
    rd_step = 1'b0;
    lit("mid_field", {30'h0, field}, 32'd1);
    lit("mid_hex", {16'h0, hexdigits}, 32'h4321);
    clr = 1'b1; tick(); clr = 1'b0;
    lit("clr_hex", {16'h0, hexdigits}, 32'h0);
    lit("clr_field", {30'h0, field}, 32'd0);
    lit("clr_empty", {31'h0, empty}, 32'd1);
    lit("clr_ntests", n_tests, 32'd0);
    lit("clr_nerr", {16'h0, n_err}, 32'd0);
    lit("clr_ready", {31'h0, in_ready}, 32'd1);

    // Saturation of the error counter, reachable only without back-pressure
    if (OVW) begin
      in_valid = 1'b1; in_s = 16'h0000; in_chk = 16'h0001;
      for (int i = 0; i < 65540; i++) begin
        in_a = 16'(i); in_b = 16'(i + 1);
        tick();
      end
      in_valid = 1'b0;
      lit("sat_nerr", {16'h0, n_err}, 32'h0000FFFF);
      lit("sat_ntests", n_tests, 32'd65540);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
